// File: rtl/muldiv_seq.sv
// =============================================================================
// Module   : muldiv_seq
// Purpose  : Iterative 32-step multiply/divide sequencer that owns the HI/LO
//            registers. Define MULDIV_DIV_EN to compile in the divide path.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] busA_i,
    input  logic [31:0] busB_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] acc_q;
    logic [5:0]  cnt_q;
    logic        sa_q;
    logic        sb_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;

    logic        is_mul_d;
    logic        is_signed_d;
    logic [32:0] mul_sum_d;
    logic [63:0] mul_acc_d;
    logic [63:0] prod_fix_d;

    always_comb begin
        is_mul_d    = (op_i[2:1] == 2'b00);
        is_signed_d = ~op_i[0];
        // 33-bit add so the carry out of the upper half is shifted back in
        mul_sum_d   = {1'b0, acc_q[63:32]} + (b_q[0] ? {1'b0, a_q} : 33'd0);
        mul_acc_d   = {mul_sum_d, acc_q[31:1]};
        prod_fix_d  = (sa_q ^ sb_q) ? -acc_q : acc_q;
    end

`ifdef MULDIV_DIV_EN
    logic        div_q;
    logic        is_div_d;
    logic [32:0] div_shift_d;
    logic [32:0] div_trial_d;
    logic [63:0] div_acc_d;
    logic [31:0] quot_fix_d;
    logic [31:0] rem_fix_d;

    // Dividend bits enter the remainder from the MSB of a_q; the quotient
    // builds up in the low half of the accumulator.
    always_comb begin
        is_div_d    = (op_i[2:1] == 2'b01);
        div_shift_d = {acc_q[63:32], a_q[31]};
        div_trial_d = div_shift_d - {1'b0, b_q};
        div_acc_d   = div_trial_d[32] ? {div_shift_d[31:0], acc_q[30:0], 1'b0}
                                      : {div_trial_d[31:0], acc_q[30:0], 1'b1};
        quot_fix_d  = (sa_q ^ sb_q) ? -acc_q[31:0] : acc_q[31:0];
        // With a zero divisor the remainder ends as the dividend magnitude,
        // so restoring its sign reproduces the raw dividend.
        rem_fix_d   = sa_q ? -acc_q[63:32] : acc_q[63:32];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (flush_i) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
`ifdef MULDIV_DIV_EN
                            if (is_mul_d || is_div_d) begin
                                div_q <= is_div_d;
`else
                            if (is_mul_d) begin
`endif
                                a_q     <= (is_signed_d && busA_i[31]) ? -busA_i : busA_i;
                                b_q     <= (is_signed_d && busB_i[31]) ? -busB_i : busB_i;
                                sa_q    <= is_signed_d & busA_i[31];
                                sb_q    <= is_signed_d & busB_i[31];
                                acc_q   <= '0;
                                cnt_q   <= '0;
                                busy_q  <= 1'b1;
                                state_q <= CALC;
                            end else if (op_i == 3'b100) begin
                                hi_q <= busA_i;
                            end else if (op_i == 3'b101) begin
                                lo_q <= busA_i;
                            end
                        end
                    end
                    CALC: begin
`ifdef MULDIV_DIV_EN
                        if (div_q) begin
                            acc_q <= div_acc_d;
                            a_q   <= {a_q[30:0], 1'b0};
                        end else begin
                            acc_q <= mul_acc_d;
                            b_q   <= {1'b0, b_q[31:1]};
                        end
`else
                        acc_q <= mul_acc_d;
                        b_q   <= {1'b0, b_q[31:1]};
`endif
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31) begin
                            state_q <= FIX;
                        end
                    end
                    FIX: begin
`ifdef MULDIV_DIV_EN
                        if (div_q) begin
                            hi_q <= rem_fix_d;
                            lo_q <= (b_q == 32'd0) ? 32'hFFFF_FFFF : quot_fix_d;
                        end else
`endif
                        begin
                            hi_q <= prod_fix_d[63:32];
                            lo_q <= prod_fix_d[31:0];
                        end
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// =============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Directed self-checking bench for muldiv_seq (divide checks follow
//            the MULDIV_DIV_EN build option).
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] busA_i;
    logic [31:0] busB_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b111;

    muldiv_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .op_i    (op_i),
        .busA_i  (busA_i),
        .busB_i  (busB_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds start for one cycle; returns 1 time unit after the sampling edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i = 1'b1;
        op_i    = op;
        busA_i  = a;
        busB_i  = b;
        step(1);
        start_i = 1'b0;
        op_i    = OP_NOP;
        busA_i  = '0;
        busB_i  = '0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy_o === 1'b1 && cycles < 100) begin
            step(1);
            cycles++;
        end
    endtask

    task automatic test_reset;
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %h want 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_errors++; $display("FAIL reset_done got %h want 0", done_o); end
        n_checks++; if (hi_o !== 32'h0) begin n_errors++; $display("FAIL reset_hi got %h want 0", hi_o); end
        n_checks++; if (lo_o !== 32'h0) begin n_errors++; $display("FAIL reset_lo got %h want 0", lo_o); end
    endtask

    task automatic test_mult;
        int cyc;
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_idle(cyc);
        n_checks++; if (cyc != 33) begin n_errors++; $display("FAIL mult_busy_len got %0d want 33", cyc); end
        n_checks++; if (done_o !== 1'b1) begin n_errors++; $display("FAIL mult_done got %h want 1", done_o); end
        n_checks++; if (hi_o !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL mult_hi got %h want ffffffff", hi_o); end
        n_checks++; if (lo_o !== 32'hFFFF_FFF1) begin n_errors++; $display("FAIL mult_lo got %h want fffffff1", lo_o); end
        step(1);
        n_checks++; if (done_o !== 1'b0) begin n_errors++; $display("FAIL mult_done_width got %h want 0", done_o); end

        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_idle(cyc);
        n_checks++; if (hi_o !== 32'h4000_0000) begin n_errors++; $display("FAIL mult_minmin_hi got %h want 40000000", hi_o); end
        n_checks++; if (lo_o !== 32'h0) begin n_errors++; $display("FAIL mult_minmin_lo got %h want 0", lo_o); end
    endtask

    task automatic test_multu;
        int cyc;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(cyc);
        n_checks++; if (cyc != 33) begin n_errors++; $display("FAIL multu_busy_len got %0d want 33", cyc); end
        n_checks++; if (done_o !== 1'b1) begin n_errors++; $display("FAIL multu_done got %h want 1", done_o); end
        n_checks++; if (hi_o !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL multu_hi got %h want fffffffe", hi_o); end
        n_checks++; if (lo_o !== 32'h0000_0001) begin n_errors++; $display("FAIL multu_lo got %h want 00000001", lo_o); end
        exp_hi = 32'hFFFF_FFFE;
        exp_lo = 32'h0000_0001;
    endtask

    task automatic test_divide;
        int cyc;
`ifdef MULDIV_DIV_EN
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(cyc);
        n_checks++; if (cyc != 33) begin n_errors++; $display("FAIL div_busy_len got %0d want 33", cyc); end
        n_checks++; if (done_o !== 1'b1) begin n_errors++; $display("FAIL div_done got %h want 1", done_o); end
        n_checks++; if (lo_o !== 32'hFFFF_FFFD) begin n_errors++; $display("FAIL div_lo got %h want fffffffd", lo_o); end
        n_checks++; if (hi_o !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL div_hi got %h want ffffffff", hi_o); end

        issue(OP_DIVU, 32'd7, 32'd0);
        wait_idle(cyc);
        n_checks++; if (lo_o !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL divu0_lo got %h want ffffffff", lo_o); end
        n_checks++; if (hi_o !== 32'd7) begin n_errors++; $display("FAIL divu0_hi got %h want 7", hi_o); end

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
        wait_idle(cyc);
        n_checks++; if (lo_o !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL div0_lo got %h want ffffffff", lo_o); end
        n_checks++; if (hi_o !== 32'hFFFF_FFF9) begin n_errors++; $display("FAIL div0_hi got %h want fffffff9", hi_o); end

        issue(OP_DIVU, 32'd100, 32'd7);
        wait_idle(cyc);
        n_checks++; if (lo_o !== 32'd14) begin n_errors++; $display("FAIL divu_lo got %h want e", lo_o); end
        n_checks++; if (hi_o !== 32'd2) begin n_errors++; $display("FAIL divu_hi got %h want 2", hi_o); end

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        n_checks++; if (lo_o !== 32'h8000_0000) begin n_errors++; $display("FAIL divovf_lo got %h want 80000000", lo_o); end
        n_checks++; if (hi_o !== 32'h0) begin n_errors++; $display("FAIL divovf_hi got %h want 0", hi_o); end
        exp_hi = 32'h0;
        exp_lo = 32'h8000_0000;
`else
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL nodiv_busy got %h want 0", busy_o); end
        step(2);
        n_checks++; if (done_o !== 1'b0) begin n_errors++; $display("FAIL nodiv_done got %h want 0", done_o); end
        n_checks++; if (hi_o !== exp_hi) begin n_errors++; $display("FAIL nodiv_hi got %h want %h", hi_o, exp_hi); end
        n_checks++; if (lo_o !== exp_lo) begin n_errors++; $display("FAIL nodiv_lo got %h want %h", lo_o, exp_lo); end
        issue(OP_DIVU, 32'd7, 32'd0);
        wait_idle(cyc);
        n_checks++; if (cyc != 0) begin n_errors++; $display("FAIL nodivu_busy got %0d want 0", cyc); end
`endif
    endtask

    task automatic test_move;
        int cyc;
        issue(OP_MTLO, 32'h0000_1234, 32'h0);
        n_checks++; if (lo_o !== 32'h0000_1234) begin n_errors++; $display("FAIL mtlo_lo got %h want 00001234", lo_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL mtlo_busy got %h want 0", busy_o); end
        n_checks++; if (hi_o !== exp_hi) begin n_errors++; $display("FAIL mtlo_hi got %h want %h", hi_o, exp_hi); end
        issue(OP_MULT, 32'd6, 32'd7);
        step(3);
        issue(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
        n_checks++; if (hi_o !== exp_hi) begin n_errors++; $display("FAIL mthi_busy_hi got %h want %h", hi_o, exp_hi); end
        n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL mthi_busy got %h want 1", busy_o); end
        wait_idle(cyc);
        n_checks++; if (done_o !== 1'b1) begin n_errors++; $display("FAIL move_mult_done got %h want 1", done_o); end
        n_checks++; if (hi_o !== 32'h0) begin n_errors++; $display("FAIL move_mult_hi got %h want 0", hi_o); end
        n_checks++; if (lo_o !== 32'd42) begin n_errors++; $display("FAIL move_mult_lo got %h want 2a", lo_o); end
        step(1);
        issue(OP_NOP, 32'h5555_5555, 32'h1);
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL nop_busy got %h want 0", busy_o); end
        n_checks++; if (hi_o !== 32'h0 || lo_o !== 32'd42) begin n_errors++; $display("FAIL nop_hilo got %h_%h want 00000000_0000002a", hi_o, lo_o); end
        issue(OP_MTHI, 32'h0000_A5A5, 32'h0);
        n_checks++; if (hi_o !== 32'h0000_A5A5) begin n_errors++; $display("FAIL mthi_hi got %h want 0000a5a5", hi_o); end
    endtask

    task automatic test_flush;
        int dones = 0;
        issue(OP_MULT, 32'd3, 32'd3);
        step(9);
        flush_i = 1'b1;
        step(1);
        flush_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL flush_busy got %h want 0", busy_o); end
        for (int i = 0; i < 40; i++) begin
            if (done_o === 1'b1) dones++;
            step(1);
        end
        n_checks++; if (dones != 0) begin n_errors++; $display("FAIL flush_done got %0d pulses want 0", dones); end
        n_checks++; if (hi_o !== 32'h0000_A5A5 || lo_o !== 32'd42) begin n_errors++; $display("FAIL flush_hilo got %h_%h want 0000a5a5_0000002a", hi_o, lo_o); end
        flush_i = 1'b1;
        issue(OP_MTLO, 32'h0000_7777, 32'h0);
        flush_i = 1'b0;
        n_checks++; if (lo_o !== 32'd42) begin n_errors++; $display("FAIL flush_mtlo got %h want 2a", lo_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL flush_start_busy got %h want 0", busy_o); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        issue(OP_MULT, 32'd2, 32'd3);
        wait_idle(cyc);
        n_checks++; if (done_o !== 1'b1 || lo_o !== 32'd6) begin n_errors++; $display("FAIL b2b_first got done=%h lo=%h want done=1 lo=6", done_o, lo_o); end
        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL b2b_accept got %h want 1", busy_o); end
        wait_idle(cyc);
        n_checks++; if (cyc != 33) begin n_errors++; $display("FAIL b2b_busy_len got %0d want 33", cyc); end
        n_checks++; if (hi_o !== 32'd1 || lo_o !== 32'd0) begin n_errors++; $display("FAIL b2b_second got %h_%h want 00000001_00000000", hi_o, lo_o); end
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        issue(OP_MULT, 32'd9, 32'd9);
        step(5);
        rst_n = 1'b0;
        #1;
        n_checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin n_errors++; $display("FAIL rstmid_hilo got %h_%h want 0_0", hi_o, lo_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got %h want 0", busy_o); end
        step(2);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done_o === 1'b1) dones++;
            step(1);
        end
        n_checks++; if (dones != 0) begin n_errors++; $display("FAIL rstmid_done got %0d pulses want 0", dones); end
        n_checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin n_errors++; $display("FAIL rstmid_after got %h_%h want 0_0", hi_o, lo_o); end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_i = 1'b0;
        op_i    = OP_NOP;
        busA_i  = '0;
        busB_i  = '0;
        flush_i = 1'b0;
        exp_hi  = '0;
        exp_lo  = '0;
        step(2);
        test_reset();
        rst_n = 1'b1;
        step(1);
        test_mult();
        test_multu();
        test_divide();
        test_move();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
